// File: rtl/alarm_sounder.sv
// alarm_sounder
//   Alarm output stage. It turns the time-match level into a single alarm event
//   and drives a beeping buzzer tone. It also handles the snooze and stop
//   buttons, a bounded snooze count and an automatic ring timeout.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   tick_1hz     in   one-cycle pulse once per second
//   alarmtrigger in   level from the time-compare block; its rising edge starts an alarm
//   snooze       in   debounced one-cycle pulse
//   stop         in   debounced one-cycle pulse
//   buzzer       out  tone output (square wave during the "on" half of each beat)
//   ringing      out  high while ringing
//   snoozing     out  high while snoozing
//   snooze_left  out  seconds left in the current snooze, 0 otherwise
//   snooze_used  out  snoozes taken in the current alarm event
//
// Interface protocol: all inputs are sampled on every rising edge, and there is
// no handshake. Every output is a flop that updates on the edge after the input
// event that caused it. The FSM state is held in state_q.
module alarm_sounder #(
  parameter int TONE_DIV     = 25000,
  parameter int SNOOZE_SEC   = 300,
  parameter int MAX_SNOOZE   = 3,
  parameter int RING_TIMEOUT = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       alarmtrigger,
  input  logic       snooze,
  input  logic       stop,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [9:0] snooze_left,
  output logic [2:0] snooze_used
);

  localparam logic [15:0] TONE_LAST   = 16'(TONE_DIV - 1);
  localparam logic [9:0]  SNOOZE_LOAD = 10'(SNOOZE_SEC);
  localparam logic [2:0]  MAX_USED    = 3'(MAX_SNOOZE);
  // The tick that would push ring_sec up to RING_TIMEOUT is the timeout tick.
  localparam logic [7:0]  RING_LAST   = 8'(RING_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RINGING   = 2'd1,
    S_SNOOZE    = 2'd2,
    S_DISMISSED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        trig_q, trig_d;
  logic        beat_q, beat_d;
  logic [15:0] tone_cnt_q, tone_cnt_d;
  logic [7:0]  ring_sec_q, ring_sec_d;
  logic        buzzer_q, buzzer_d;
  logic        ringing_q, ringing_d;
  logic        snoozing_q, snoozing_d;
  logic [9:0]  snooze_left_q, snooze_left_d;
  logic [2:0]  snooze_used_q, snooze_used_d;

  logic rise;
  logic enter_ring;
  logic tone_on_q;
  logic tone_on_d;

  always_comb begin
    rise          = alarmtrigger & ~trig_q;
    enter_ring    = 1'b0;
    state_d       = state_q;
    trig_d        = alarmtrigger;
    beat_d        = beat_q;
    ring_sec_d    = ring_sec_q;
    snooze_left_d = snooze_left_q;
    snooze_used_d = snooze_used_q;

    case (state_q)
      S_IDLE: begin
        if (rise) enter_ring = 1'b1;
      end
      S_RINGING: begin
        if (stop) begin
          state_d = S_DISMISSED;
        end else if (snooze && (snooze_used_q < MAX_USED)) begin
          state_d       = S_SNOOZE;
          snooze_used_d = snooze_used_q + 3'd1;
          snooze_left_d = SNOOZE_LOAD;
        end else if (tick_1hz) begin
          // A snooze press at the limit falls through to here and is ignored.
          if (ring_sec_q == RING_LAST) begin
            state_d = S_DISMISSED;
          end else begin
            ring_sec_d = ring_sec_q + 8'd1;
            beat_d     = ~beat_q;
          end
        end
      end
      S_SNOOZE: begin
        if (stop) begin
          state_d       = S_DISMISSED;
          snooze_left_d = 10'd0;
        end else if (tick_1hz) begin
          snooze_left_d = snooze_left_q - 10'd1;
          // The snooze expires and the alarm rings again, whatever the trigger level is now.
          if (snooze_left_q == 10'd1) enter_ring = 1'b1;
        end
      end
      S_DISMISSED: begin
        // The alarm stays here until the matching minute ends, so it cannot re-ring.
        if (!alarmtrigger) begin
          state_d       = S_IDLE;
          snooze_used_d = 3'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_ring) begin
      state_d    = S_RINGING;
      ring_sec_d = 8'd0;
      beat_d     = 1'b1;
    end

    ringing_d  = (state_d == S_RINGING);
    snoozing_d = (state_d == S_SNOOZE);

    // The tone runs only during the "on" half of the beat. Each new on-phase
    // restarts from count 0 with the buzzer low, so the first toggle comes
    // TONE_DIV cycles after the on-phase begins.
    tone_on_q = (state_q == S_RINGING) && beat_q;
    tone_on_d = (state_d == S_RINGING) && beat_d;
    if (!tone_on_d || !tone_on_q) begin
      tone_cnt_d = 16'd0;
      buzzer_d   = 1'b0;
    end else if (tone_cnt_q == TONE_LAST) begin
      tone_cnt_d = 16'd0;
      buzzer_d   = ~buzzer_q;
    end else begin
      tone_cnt_d = tone_cnt_q + 16'd1;
      buzzer_d   = buzzer_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      trig_q        <= 1'b0;
      beat_q        <= 1'b0;
      tone_cnt_q    <= 16'd0;
      ring_sec_q    <= 8'd0;
      buzzer_q      <= 1'b0;
      ringing_q     <= 1'b0;
      snoozing_q    <= 1'b0;
      snooze_left_q <= 10'd0;
      snooze_used_q <= 3'd0;
    end else begin
      state_q       <= state_d;
      trig_q        <= trig_d;
      beat_q        <= beat_d;
      tone_cnt_q    <= tone_cnt_d;
      ring_sec_q    <= ring_sec_d;
      buzzer_q      <= buzzer_d;
      ringing_q     <= ringing_d;
      snoozing_q    <= snoozing_d;
      snooze_left_q <= snooze_left_d;
      snooze_used_q <= snooze_used_d;
    end
  end

  assign buzzer      = buzzer_q;
  assign ringing     = ringing_q;
  assign snoozing    = snoozing_q;
  assign snooze_left = snooze_left_q;
  assign snooze_used = snooze_used_q;

endmodule
